// File: rtl/uart_tx_param.sv
// UART transmitter with run-time selectable data width, parity, stop bits and baud divisor.
// Frame settings are captured when a frame is accepted, so inputs may change freely mid-frame.
module uart_tx_param #(
    parameter int DATA_WIDTH = 9,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  txDataValid,
    input  logic [DATA_WIDTH-1:0] txDataIn,
    input  logic [DIV_WIDTH-1:0]  clocksPerBit,
    input  logic [3:0]            dataBits,
    input  logic [1:0]            parityMode,
    input  logic                  twoStop,
    input  logic                  breakReq,
    output logic                  txReady,
    output logic                  tx,
    output logic                  busy,
    output logic                  txDone
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } stateT;

    localparam logic [3:0] MIN_BITS = 4'd5;
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

    stateT                 stateQ, stateD;
    logic [DIV_WIDTH-1:0]  cntQ, cntD;
    logic [3:0]            bitCntQ, bitCntD;
    logic [DATA_WIDTH-1:0] shiftQ, shiftD;
    logic                  txQ, txD;
    logic                  txDoneQ, txDoneD;
    logic [DIV_WIDTH-1:0]  cpbQ, cpbD;
    logic [3:0]            nBitsQ, nBitsD;
    logic                  parEnQ, parEnD;
    logic                  parBitQ, parBitD;
    logic                  twoStopQ, twoStopD;

    logic [3:0]            nBitsClamp;
    logic [DATA_WIDTH-1:0] maskedData;
    logic [DIV_WIDTH-1:0]  cpbEff;
    logic                  bitEnd;
    logic                  lastStop;

    always_comb begin
        nBitsClamp = dataBits;
        if (dataBits < MIN_BITS) begin
            nBitsClamp = MIN_BITS;
        end else if (dataBits > MAX_BITS) begin
            nBitsClamp = MAX_BITS;
        end
    end

    // Parity only covers the bits that will actually leave on the line.
    always_comb begin
        maskedData = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            maskedData[i] = txDataIn[i] & (4'(i) < nBitsClamp);
        end
    end

    assign cpbEff   = (clocksPerBit == '0) ? DIV_WIDTH'(1) : clocksPerBit;
    assign bitEnd   = (cntQ >= cpbQ);
    assign lastStop = twoStopQ ? (bitCntQ >= 4'd2) : 1'b1;

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        bitCntD  = bitCntQ;
        shiftD   = shiftQ;
        txD      = txQ;
        cpbD     = cpbQ;
        nBitsD   = nBitsQ;
        parEnD   = parEnQ;
        parBitD  = parBitQ;
        twoStopD = twoStopQ;

        case (stateQ)
            IDLE: begin
                txD = 1'b1;
                if (breakReq) begin
                    stateD = BREAK;
                    txD    = 1'b0;
                end else if (txDataValid) begin
                    stateD   = START;
                    txD      = 1'b0;
                    cntD     = DIV_WIDTH'(1);
                    bitCntD  = 4'd1;
                    shiftD   = txDataIn;
                    cpbD     = cpbEff;
                    nBitsD   = nBitsClamp;
                    parEnD   = (parityMode == 2'b01) || (parityMode == 2'b10);
                    parBitD  = (^maskedData) ^ (parityMode == 2'b10);
                    twoStopD = twoStop;
                end
            end
            BREAK: begin
                txD = 1'b0;
                if (!breakReq) begin
                    stateD = IDLE;
                    txD    = 1'b1;
                end
            end
            default: begin
                if (!bitEnd) begin
                    cntD = cntQ + DIV_WIDTH'(1);
                end else begin
                    cntD = DIV_WIDTH'(1);
                    case (stateQ)
                        START: begin
                            stateD  = DATA;
                            txD     = shiftQ[0];
                            shiftD  = {1'b0, shiftQ[DATA_WIDTH-1:1]};
                            bitCntD = 4'd1;
                        end
                        DATA: begin
                            if (bitCntQ >= nBitsQ) begin
                                bitCntD = 4'd1;
                                if (parEnQ) begin
                                    stateD = PARITY;
                                    txD    = parBitQ;
                                end else begin
                                    stateD = STOP;
                                    txD    = 1'b1;
                                end
                            end else begin
                                txD     = shiftQ[0];
                                shiftD  = {1'b0, shiftQ[DATA_WIDTH-1:1]};
                                bitCntD = bitCntQ + 4'd1;
                            end
                        end
                        PARITY: begin
                            stateD  = STOP;
                            txD     = 1'b1;
                            bitCntD = 4'd1;
                        end
                        STOP: begin
                            txD = 1'b1;
                            if (lastStop) begin
                                stateD = IDLE;
                            end else begin
                                bitCntD = bitCntQ + 4'd1;
                            end
                        end
                        default: begin
                            stateD = IDLE;
                            txD    = 1'b1;
                        end
                    endcase
                end
            end
        endcase

        // Look ahead so txDone is high during the final stop cycle, the one ending in STOP->IDLE.
        txDoneD = (stateD == STOP) && (cntD >= cpbD) &&
                  (twoStopD ? (bitCntD >= 4'd2) : 1'b1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ   <= IDLE;
            cntQ     <= DIV_WIDTH'(1);
            bitCntQ  <= 4'd1;
            shiftQ   <= '0;
            txQ      <= 1'b1;
            txDoneQ  <= 1'b0;
            cpbQ     <= DIV_WIDTH'(1);
            nBitsQ   <= MIN_BITS;
            parEnQ   <= 1'b0;
            parBitQ  <= 1'b0;
            twoStopQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            bitCntQ  <= bitCntD;
            shiftQ   <= shiftD;
            txQ      <= txD;
            txDoneQ  <= txDoneD;
            cpbQ     <= cpbD;
            nBitsQ   <= nBitsD;
            parEnQ   <= parEnD;
            parBitQ  <= parBitD;
            twoStopQ <= twoStopD;
        end
    end

    assign txReady = (stateQ == IDLE) && !breakReq;
    assign busy    = (stateQ != IDLE);
    assign tx      = txQ;
    assign txDone  = txDoneQ;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: expected frames are queued when requested and
// checked cycle by cycle against the serial line when they appear.
module tb_uart_tx_param;

    logic        clk;
    logic        resetN;
    logic        txDataValid;
    logic [8:0]  txDataIn;
    logic [15:0] clocksPerBit;
    logic [3:0]  dataBits;
    logic [1:0]  parityMode;
    logic        twoStop;
    logic        breakReq;
    logic        txReady;
    logic        tx;
    logic        busy;
    logic        txDone;

    int total;
    int bad;

    typedef struct {
        logic [12:0] bits;
        int          len;
        int          cpb;
    } frameT;

    frameT expQ[$];

    uart_tx_param #(
        .DATA_WIDTH(9),
        .DIV_WIDTH (16)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .txDataValid (txDataValid),
        .txDataIn    (txDataIn),
        .clocksPerBit(clocksPerBit),
        .dataBits    (dataBits),
        .parityMode  (parityMode),
        .twoStop     (twoStop),
        .breakReq    (breakReq),
        .txReady     (txReady),
        .tx          (tx),
        .busy        (busy),
        .txDone      (txDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frameT buildFrame(input logic [8:0] data, input logic [3:0] nb,
                                         input logic [1:0] pm, input logic two,
                                         input logic [15:0] cpb);
        frameT f;
        int    n;
        int    idx;
        logic  par;
        n = (nb < 5) ? 5 : ((nb > 9) ? 9 : int'(nb));
        f.bits = '1;
        f.bits[0] = 1'b0;
        par = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = data[i];
            par = par ^ data[i];
        end
        idx = 1 + n;
        if (pm == 2'b01) begin
            f.bits[idx] = par;
            idx++;
        end else if (pm == 2'b10) begin
            f.bits[idx] = ~par;
            idx++;
        end
        f.len = idx + (two ? 2 : 1);
        f.cpb = (cpb == 16'd0) ? 1 : int'(cpb);
        return f;
    endfunction

    task automatic driveInputs(input logic [8:0] data, input logic [3:0] nb,
                               input logic [1:0] pm, input logic two, input logic [15:0] cpb);
        txDataIn     = data;
        dataBits     = nb;
        parityMode   = pm;
        twoStop      = two;
        clocksPerBit = cpb;
    endtask

    // Requests one frame, records its expected shape, then scrambles the inputs once it is taken.
    task automatic applyStimulus(input string tag, input logic [8:0] data, input logic [3:0] nb,
                                 input logic [1:0] pm, input logic two, input logic [15:0] cpb);
        @(negedge clk);
        driveInputs(data, nb, pm, two, cpb);
        txDataValid = 1'b1;
        expQ.push_back(buildFrame(data, nb, pm, two, cpb));
        #1;
        checkVal({tag, " txReady"}, 32'(txReady), 32'd1);
        @(posedge clk);
        #1;
        txDataValid  = 1'b0;
        txDataIn     = 9'($urandom);
        dataBits     = 4'($urandom);
        parityMode   = 2'($urandom);
        twoStop      = 1'($urandom);
        clocksPerBit = 16'($urandom_range(1, 7));
    endtask

    task automatic checkOutput(input string tag);
        frameT f;
        int    waited;
        bit    started;
        int    frameLen;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s scoreboard observed=empty expected=frame", tag);
            return;
        end
        f = expQ.pop_front();
        waited  = 0;
        started = 1'b0;
        while (!started && waited < 300) begin
            @(negedge clk);
            if (tx === 1'b0) started = 1'b1;
            else waited++;
        end
        checkVal({tag, " startDelay"}, 32'(waited), 32'd0);
        if (!started) return;
        frameLen = f.len * f.cpb;
        for (int k = 0; k < frameLen; k++) begin
            if (k > 0) @(negedge clk);
            checkVal($sformatf("%s bit%0d cyc%0d tx", tag, k / f.cpb, k % f.cpb),
                     32'(tx), 32'(f.bits[k / f.cpb]));
            checkVal($sformatf("%s cyc%0d txDone", tag, k), 32'(txDone), 32'(k == frameLen - 1));
        end
        checkVal({tag, " busyLast"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkVal({tag, " idleTx"}, 32'(tx), 32'd1);
        checkVal({tag, " idleBusy"}, 32'(busy), 32'd0);
        checkVal({tag, " idleDone"}, 32'(txDone), 32'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        resetN      = 1'b1;
        txDataValid = 1'b0;
        breakReq    = 1'b0;
        driveInputs(9'h000, 4'd8, 2'b00, 1'b0, 16'd4);

        // Asynchronous reset, checked before any clock edge.
        #2 resetN = 1'b0;
        #1;
        checkVal("reset tx", 32'(tx), 32'd1);
        checkVal("reset busy", 32'(busy), 32'd0);
        checkVal("reset txDone", 32'(txDone), 32'd0);
        checkVal("reset txReady", 32'(txReady), 32'd1);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        applyStimulus("f55", 9'h055, 4'd8, 2'b00, 1'b0, 16'd4);
        checkOutput("f55");

        applyStimulus("even03", 9'h003, 4'd7, 2'b01, 1'b0, 16'd2);
        checkOutput("even03");
        applyStimulus("odd03", 9'h003, 4'd7, 2'b10, 1'b0, 16'd2);
        checkOutput("odd03");
        applyStimulus("even83", 9'h083, 4'd7, 2'b01, 1'b0, 16'd2);
        checkOutput("even83");

        applyStimulus("twoStop", 9'h016, 4'd5, 2'b10, 1'b1, 16'd3);
        checkOutput("twoStop");

        applyStimulus("cpb0", 9'h03C, 4'd8, 2'b01, 1'b0, 16'd0);
        checkOutput("cpb0");
        applyStimulus("bits2", 9'h01F, 4'd2, 2'b01, 1'b0, 16'd2);
        checkOutput("bits2");
        applyStimulus("bits15", 9'h1A5, 4'd15, 2'b01, 1'b0, 16'd2);
        checkOutput("bits15");

        // Valid held high across two frames.
        @(negedge clk);
        driveInputs(9'h03A, 4'd8, 2'b00, 1'b0, 16'd2);
        txDataValid = 1'b1;
        expQ.push_back(buildFrame(9'h03A, 4'd8, 2'b00, 1'b0, 16'd2));
        expQ.push_back(buildFrame(9'h03A, 4'd8, 2'b00, 1'b0, 16'd2));
        fork
            begin
                checkOutput("b2b1");
                checkOutput("b2b2");
            end
            begin
                repeat (22) @(posedge clk);
                #1 txDataValid = 1'b0;
            end
        join

        // Break with a pending frame request.
        @(negedge clk);
        driveInputs(9'h05A, 4'd8, 2'b01, 1'b0, 16'd2);
        breakReq    = 1'b1;
        txDataValid = 1'b1;
        expQ.push_back(buildFrame(9'h05A, 4'd8, 2'b01, 1'b0, 16'd2));
        #1;
        checkVal("break txReadyNow", 32'(txReady), 32'd0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkVal($sformatf("break cyc%0d tx", i), 32'(tx), 32'd0);
            checkVal($sformatf("break cyc%0d txReady", i), 32'(txReady), 32'd0);
        end
        breakReq = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 txDataValid = 1'b0;
        checkOutput("afterBreak");

        applyStimulus("midBreak", 9'h096, 4'd8, 2'b10, 1'b1, 16'd2);
        fork
            checkOutput("midBreak");
            begin
                repeat (6) @(negedge clk);
                breakReq = 1'b1;
                repeat (10) @(negedge clk);
                breakReq = 1'b0;
            end
        join

        // Reset pulse in the third data bit of an all-zero frame.
        @(negedge clk);
        driveInputs(9'h000, 4'd8, 2'b00, 1'b0, 16'd4);
        txDataValid = 1'b1;
        @(posedge clk);
        #1 txDataValid = 1'b0;
        repeat (13) @(negedge clk);
        checkVal("preReset tx", 32'(tx), 32'd0);
        #2 resetN = 1'b0;
        #1;
        checkVal("midReset tx", 32'(tx), 32'd1);
        checkVal("midReset busy", 32'(busy), 32'd0);
        checkVal("midReset txDone", 32'(txDone), 32'd0);
        checkVal("midReset txReady", 32'(txReady), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal($sformatf("inReset cyc%0d txDone", i), 32'(txDone), 32'd0);
            checkVal($sformatf("inReset cyc%0d tx", i), 32'(tx), 32'd1);
        end
        resetN = 1'b1;
        applyStimulus("postReset", 9'h0A5, 4'd8, 2'b00, 1'b0, 16'd4);
        checkOutput("postReset");

        checkVal("queueEmpty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have a parameter DATA_WIDTH, default 9, giving the maximum data bits per frame (legal range 5..9).
REQ-002 The block SHALL have a parameter DIV_WIDTH, default 16, giving the width of the baud divisor.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port txDataValid, input, 1 bit: a frame request is present.
REQ-006 Port txDataIn, input, DATA_WIDTH bits: frame data, LSB transmitted first.
REQ-007 Port clocksPerBit, input, DIV_WIDTH bits: clk cycles per bit period.
REQ-008 Port dataBits, input, 4 bits: number of data bits per frame.
REQ-009 Port parityMode, input, 2 bits: 00 none, 01 even, 10 odd, 11 none.
REQ-010 Port twoStop, input, 1 bit: 0 gives one stop bit, 1 gives two.
REQ-011 Port breakReq, input, 1 bit: drive a line break.
REQ-012 Port txReady, output, 1 bit: the block can accept a frame this cycle.
REQ-013 Port tx, output, 1 bit: serial line, registered.
REQ-014 Port busy, output, 1 bit: a frame or break is in progress.
REQ-015 Port txDone, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-016 The block SHALL use the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-017 txReady SHALL be 1 only in IDLE with breakReq=0; busy SHALL equal NOT IDLE.
REQ-018 A frame SHALL be accepted when txReady=1 and txDataValid=1 on a clk edge.
- On acceptance, txDataIn, dataBits, parityMode, twoStop and clocksPerBit SHALL be latched.
- Input changes during a frame SHALL have no effect on that frame.
REQ-019 Latched clocksPerBit=0 SHALL be treated as 1.
REQ-020 Latched dataBits SHALL be clamped to the range 5..DATA_WIDTH.
REQ-021 Each bit SHALL last exactly clocksPerBit cycles.
- A cycle counter SHALL run 1..clocksPerBit and reset to 1 on every bit boundary.
- The counter SHALL compare with >= so it cannot overrun.
REQ-022 tx SHALL be registered; tx SHALL go to 0 (START) on the clk edge after acceptance.
REQ-023 Frame sequence on tx:
- start bit 0;
- dataBits data bits, LSB first, using a shift register;
- a parity bit if the mode is even or odd;
- 1 or 2 stop bits of value 1.
REQ-024 Parity SHALL be computed over the transmitted data bits only.
- Even: XOR of those bits.
- Odd: the inverse of that XOR.
REQ-025 State transitions:
- IDLE to START on acceptance;
- START to DATA after one bit period;
- DATA to PARITY, or to STOP when no parity, after the last data bit;
- PARITY to STOP after one bit period;
- STOP to IDLE after the configured number of stop-bit periods.
REQ-026 txDone SHALL pulse for exactly one cycle, coincident with the transition STOP to IDLE.
REQ-027 In IDLE, tx SHALL be 1. There SHALL be at least one idle clk between the last stop bit and the next start bit.
REQ-028 Total frame length SHALL be (1 + N + P + S) x clocksPerBit cycles, where N = data bits, P = parity bit count (0/1) and S = stop bit count (1/2).
REQ-029 breakReq=1 in IDLE SHALL take priority over txDataValid and enter BREAK.
- In BREAK, tx SHALL be 0 and txReady SHALL be 0.
- BREAK SHALL exit to IDLE on the first edge with breakReq=0.
REQ-030 breakReq asserted during a frame SHALL be ignored until the frame returns to IDLE.
REQ-031 txDataValid held high continuously SHALL send back-to-back frames separated by exactly one idle clk.

Reset
REQ-032 resetN=0 SHALL immediately force the following, independent of clk:
- state IDLE;
- tx=1, txDone=0, busy=0;
- cycle counter and bit counter to 1;
- data shift register to 0.
REQ-033 With resetN=0 and breakReq=0, txReady SHALL read 1 combinationally.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no txDone.
- tx SHALL return to 1 immediately.
- The first frame after release SHALL be complete and correct.

Verification
REQ-035 Stimulus: clocksPerBit=4, dataBits=8, parity none, one stop bit, txDataIn=0x55. Required: tx = 0, then 1,0,1,0,1,0,1,0, then 1, each bit held 4 clk; frame lasts 40 clk; txDone pulses once.
REQ-036 Stimulus: dataBits=7, parity even, txDataIn=0x03. Required: parity bit 0. Stimulus: parity odd, same data. Required: parity bit 1. Stimulus: dataBits=7, txDataIn=0x83. Required: bit 7 is not sent and parity is unchanged.
REQ-037 Stimulus: twoStop=1, clocksPerBit=3, dataBits=5, parity odd. Required: frame lasts 27 clk; tx=1 for 6 clk of stop bits; busy falls on the cycle after txDone.
REQ-038 Stimulus: clocksPerBit=0, and separately dataBits=2 and dataBits=15. Required: the block behaves as clocksPerBit=1, and as dataBits=5 and dataBits=9 respectively.
REQ-039 Stimulus: breakReq=1 for 50 clk while txDataValid=1. Required: tx=0 and txReady=0 for the whole window; the frame starts after breakReq falls. Stimulus: breakReq raised mid-frame. Required: the frame is unchanged.
REQ-040 Stimulus: resetN pulsed low during the 3rd data bit. Required: tx=1 asynchronously, no txDone; the next frame with 0xA5 is bit-exact.
